// File: rtl/mult_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_pkg
//  Description : Shared types and constants for the multiplier arbiter slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    localparam int SIZE_DEF = 16;
    localparam int NREQ_DEF = 4;
    localparam int ID_W     = $clog2(NREQ_DEF);
    localparam int PROD_W   = 2 * SIZE_DEF;

    // Arbiter sequencing: pick a requester, wait for the array, hand back the product
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Next requester index after id, wrapping at n
    function automatic int next_idx(input int id, input int n);
        return (id + 1 == n) ? 0 : id + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mult_arbiter_if
//  Description : Requester, response and multiplier-side signals of the
//                shared-multiplier arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mult_arbiter_if #(
    parameter int SIZE = 16,
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*SIZE-1:0] req_a;
    logic [NREQ*SIZE-1:0] req_b;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_ready;
    logic [2*SIZE-1:0]    rsp_p;
    logic [SIZE-1:0]      mult_a;
    logic [SIZE-1:0]      mult_b;
    logic [2*SIZE-1:0]    mult_p;
    logic [2*SIZE-1:0]    mult_v;
    logic                 err;
    logic                 busy;

    // Requesters plus the external multiplier
    modport master (
        output req_valid, req_a, req_b, rsp_ready, mult_p, mult_v,
        input  req_ready, rsp_valid, rsp_p, mult_a, mult_b, err, busy
    );

    // The arbiter itself
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, mult_p, mult_v,
        output req_ready, rsp_valid, rsp_p, mult_a, mult_b, err, busy
    );
endinterface
`default_nettype wire

// File: rtl/mult_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin search; first set request at or
//                above ptr, wrapping past NREQ-1 back to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  wire logic [NREQ-1:0] req,
    input  wire logic [ID_W-1:0] ptr,
    output logic      [ID_W-1:0] win,
    output logic                 any
);

    logic [ID_W-1:0] w_idx;

    // Scan offsets from farthest to nearest so the nearest hit is the last write
    always_comb begin
        win   = ptr;
        any   = 1'b0;
        w_idx = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            w_idx = ID_W'((int'(ptr) + off) % NREQ);
            if (req[w_idx]) begin
                win = w_idx;
                any = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mult_arbiter
//  Description : Round-robin sharing of one external array multiplier among
//                NREQ requesters, with product capture after a fixed settle
//                latency and a sticky product/verification mismatch flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_arbiter
    import mult_pkg::*;
#(
    parameter int SIZE = 16,
    parameter int NREQ = 4,
    parameter int LAT  = 2
) (
    input  wire logic    clk,
    input  wire logic    rst,
    mult_arbiter_if.slave bus
);

    localparam int c_ID_W   = $clog2(NREQ);
    localparam int c_CNT_W  = $clog2(LAT);
    localparam int c_PROD_W = 2 * SIZE;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_ID_W-1:0]   r_ptr;
    logic [c_ID_W-1:0]   r_id;
    logic [c_ID_W-1:0]   w_win;
    logic                w_any;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [SIZE-1:0]     r_mult_a;
    logic [SIZE-1:0]     r_mult_b;
    logic [c_PROD_W-1:0] r_rsp_p;
    logic                r_err;
    logic                w_accept;
    logic                w_capture;
    logic                w_rsp_done;

    rr_pick #(
        .NREQ (NREQ),
        .ID_W (c_ID_W)
    ) u_pick (
        .req  (bus.req_valid),
        .ptr  (r_ptr),
        .win  (w_win),
        .any  (w_any)
    );

    // Next-state and handshake strobes; ready is suppressed while rst is high
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_rsp_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any && !rst) begin
                    w_accept    = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready[r_id]) begin
                    w_rsp_done  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Operand launch, settle countdown, product capture, error and pointer update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr    <= '0;
            r_id     <= '0;
            r_cnt    <= '0;
            r_mult_a <= '0;
            r_mult_b <= '0;
            r_rsp_p  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mult_a <= bus.req_a[int'(w_win)*SIZE +: SIZE];
                r_mult_b <= bus.req_b[int'(w_win)*SIZE +: SIZE];
                r_id     <= w_win;
                r_cnt    <= c_CNT_W'(LAT - 1);
            end else if (r_state == WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_capture) begin
                r_rsp_p <= bus.mult_p;
                if (bus.mult_p != bus.mult_v) r_err <= 1'b1;
            end
            if (w_rsp_done) r_ptr <= c_ID_W'(next_idx(int'(r_id), NREQ));
        end
    end

    assign bus.req_ready = w_accept ? (NREQ'(1) << w_win) : '0;
    assign bus.rsp_valid = (r_state == RESP) ? (NREQ'(1) << r_id) : '0;
    assign bus.rsp_p     = r_rsp_p;
    assign bus.mult_a    = r_mult_a;
    assign bus.mult_b    = r_mult_b;
    assign bus.err       = r_err;
    assign bus.busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_arbiter
//  Description : Directed self-checking bench for mult_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_arbiter;

    localparam int SIZE = 16;
    localparam int NREQ = 4;
    localparam int LAT  = 2;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic inject = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    mult_arbiter_if #(.SIZE(SIZE), .NREQ(NREQ)) bus ();

    // Ideal multiplier; inject corrupts the verification product
    assign bus.mult_p = {16'd0, bus.mult_a} * {16'd0, bus.mult_b};
    assign bus.mult_v = inject ? (bus.mult_p ^ 32'd1) : bus.mult_p;

    mult_arbiter #(.SIZE(SIZE), .NREQ(NREQ), .LAT(LAT)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Stimulus only: request from idx, wait for the response, complete the handshake
    task automatic do_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                         output logic ok, output logic [31:0] p);
        int n;
        ok = 1'b1;
        p  = '0;
        bus.req_a[idx*SIZE +: SIZE] = a;
        bus.req_b[idx*SIZE +: SIZE] = b;
        bus.req_valid[idx] = 1'b1;
        #1;
        n = 0;
        while (!bus.req_ready[idx] && n < 20) begin tick(); n++; end
        if (!bus.req_ready[idx]) ok = 1'b0;
        tick();
        bus.req_valid[idx] = 1'b0;
        n = 0;
        while (!bus.rsp_valid[idx] && n < 20) begin tick(); n++; end
        if (!bus.rsp_valid[idx]) ok = 1'b0;
        p = bus.rsp_p;
        bus.rsp_ready[idx] = 1'b1;
        tick();
        bus.rsp_ready[idx] = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.req_valid = 4'hF;
        tick();
        n_tests++; if (bus.req_ready !== 4'h0) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready); end
        n_tests++; if (bus.rsp_valid !== 4'h0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0000", bus.rsp_valid); end
        n_tests++; if (bus.rsp_p !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_p: got %h expected 0", bus.rsp_p); end
        n_tests++; if (bus.mult_a !== 16'h0 || bus.mult_b !== 16'h0) begin n_fail++; $display("FAIL reset_mult_ab: got %h %h expected 0 0", bus.mult_a, bus.mult_b); end
        n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus.err); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        bus.req_valid = '0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single;
        do_reset();
        bus.req_a[2*SIZE +: SIZE] = 16'h00FF;
        bus.req_b[2*SIZE +: SIZE] = 16'h0101;
        bus.req_valid = 4'b0100;
        #1;
        n_tests++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b expected 0100", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        #1;
        n_tests++; if (bus.req_ready !== 4'b0000 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_after_accept: ready %b busy %b expected 0000 1", bus.req_ready, bus.busy); end
        n_tests++; if (bus.mult_a !== 16'h00FF || bus.mult_b !== 16'h0101) begin n_fail++; $display("FAIL single_operands: got %h %h expected 00ff 0101", bus.mult_a, bus.mult_b); end
        tick();
        n_tests++; if (bus.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_early_rsp: got %b expected 0000", bus.rsp_valid); end
        tick();
        n_tests++; if (bus.rsp_valid !== 4'b0100) begin n_fail++; $display("FAIL single_rsp_valid: got %b expected 0100", bus.rsp_valid); end
        n_tests++; if (bus.rsp_p !== 32'h0000FFFF) begin n_fail++; $display("FAIL single_rsp_p: got %h expected 0000ffff", bus.rsp_p); end
        n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b expected 0", bus.err); end
        bus.rsp_ready = 4'b0100;
        tick();
        bus.rsp_ready = '0;
        #1;
        n_tests++; if (bus.rsp_valid !== 4'b0000 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_done: rsp_valid %b busy %b expected 0000 0", bus.rsp_valid, bus.busy); end
    endtask

    task automatic test_round_robin;
        int order[$];
        int when[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*SIZE +: SIZE] = 16'(i + 1);
            bus.req_b[i*SIZE +: SIZE] = 16'h0010;
        end
        bus.req_valid = 4'hF;
        bus.rsp_ready = 4'hF;
        #1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_ready[i]) begin order.push_back(i); when.push_back(cyc); end
                if (bus.rsp_valid[i]) begin
                    n_tests++;
                    if (bus.rsp_p !== 32'((i + 1) * 16)) begin n_fail++; $display("FAIL rr_rsp_p[%0d]: got %h expected %h", i, bus.rsp_p, 32'((i + 1) * 16)); end
                end
            end
            tick();
        end
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        n_tests++;
        if (order.size() != 5) begin n_fail++; $display("FAIL rr_accept_count: got %0d expected 5", order.size()); end
        else begin
            for (int k = 0; k < 5; k++) begin
                n_tests++;
                if (order[k] != exp_order[k] || when[k] != 4 * k) begin
                    n_fail++;
                    $display("FAIL rr_accept[%0d]: got req %0d at cycle %0d expected req %0d at cycle %0d", k, order[k], when[k], exp_order[k], 4 * k);
                end
            end
        end
    endtask

    task automatic test_operands;
        logic ok;
        logic [31:0] p;
        do_reset();
        do_op(0, 16'hFFFF, 16'hFFFF, ok, p);
        n_tests++; if (ok !== 1'b1 || p !== 32'hFFFE0001) begin n_fail++; $display("FAIL max_operands: ok %b got %h expected fffe0001", ok, p); end
        do_op(1, 16'h0000, 16'h1234, ok, p);
        n_tests++; if (ok !== 1'b1 || p !== 32'h0) begin n_fail++; $display("FAIL zero_operand: ok %b got %h expected 0", ok, p); end
        n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL operands_err: got %b expected 0", bus.err); end
    endtask

    task automatic test_backpressure;
        do_reset();
        bus.req_a[1*SIZE +: SIZE] = 16'd3;
        bus.req_b[1*SIZE +: SIZE] = 16'd5;
        bus.req_a[0 +: SIZE] = 16'd7;
        bus.req_b[0 +: SIZE] = 16'd7;
        bus.req_valid = 4'b0010;
        #1;
        tick();
        bus.req_valid = 4'b0011;
        tick();
        tick();
        for (int c = 0; c < 5; c++) begin
            n_tests++;
            if (bus.rsp_valid !== 4'b0010 || bus.rsp_p !== 32'd15 || bus.req_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: rsp_valid %b rsp_p %h req_ready %b expected 0010 0000000f 0000", c, bus.rsp_valid, bus.rsp_p, bus.req_ready);
            end
            tick();
        end
        bus.rsp_ready = 4'b1101;
        tick();
        n_tests++; if (bus.rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL bp_other_ready: got %b expected 0010", bus.rsp_valid); end
        bus.rsp_ready = 4'b0010;
        tick();
        bus.rsp_ready = '0;
        #1;
        n_tests++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL bp_release: busy %b rsp_valid %b expected 0 0000", bus.busy, bus.rsp_valid); end
        n_tests++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_ptr_wrap: got %b expected 0001", bus.req_ready); end
        bus.req_valid = '0;
        #1;
    endtask

    task automatic test_mismatch;
        logic ok;
        logic [31:0] p;
        do_reset();
        inject = 1'b1;
        do_op(2, 16'd7, 16'd9, ok, p);
        inject = 1'b0;
        n_tests++; if (ok !== 1'b1 || p !== 32'd63) begin n_fail++; $display("FAIL mm_product: ok %b got %h expected 0000003f", ok, p); end
        n_tests++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL mm_err_set: got %b expected 1", bus.err); end
        do_op(3, 16'd2, 16'd3, ok, p);
        do_op(0, 16'd4, 16'd4, ok, p);
        n_tests++; if (bus.err !== 1'b1 || p !== 32'd16) begin n_fail++; $display("FAIL mm_err_sticky: err %b p %h expected 1 00000010", bus.err, p); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL mm_err_clear: got %b expected 0", bus.err); end
    endtask

    task automatic test_reset_wait;
        logic ok;
        logic [31:0] p;
        do_reset();
        do_op(1, 16'd2, 16'd3, ok, p);
        bus.req_a[2*SIZE +: SIZE] = 16'd5;
        bus.req_b[2*SIZE +: SIZE] = 16'd5;
        bus.req_valid = 4'b0100;
        #1;
        n_tests++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL rw_ready: got %b expected 0100", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rw_busy: got %b expected 0", bus.busy); end
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if (bus.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL rw_no_rsp[%0d]: got %b expected 0000", c, bus.rsp_valid); end
            tick();
        end
        bus.req_a[3*SIZE +: SIZE] = 16'h0010;
        bus.req_b[3*SIZE +: SIZE] = 16'h0020;
        bus.req_valid = 4'b1000;
        #1;
        n_tests++; if (bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL rw_req3_ready: got %b expected 1000", bus.req_ready); end
        do_op(3, 16'h0010, 16'h0020, ok, p);
        n_tests++; if (ok !== 1'b1 || p !== 32'h200) begin n_fail++; $display("FAIL rw_req3_product: ok %b got %h expected 00000200", ok, p); end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_operands();
        test_backpressure();
        test_mismatch();
        test_reset_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
